// File: rtl/icache_assoc_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc_if
// Brief    : Fetch, flush and AXI-bridge signal bundle of icache_assoc.
// Revision : 1.0
// ============================================================================
interface icache_assoc_if #(
    parameter int LINE_WORDS = 8
);
    logic                     cpu_req_valid;
    logic [31:0]              cpu_req_addr;
    logic                     cpu_req_ready;
    logic                     cpu_resp_valid;
    logic [31:0]              cpu_resp_data;
    logic                     cpu_resp_ready;
    logic                     flush_req;
    logic                     flush_busy;
    logic                     mem_rd_req;
    logic [31:0]              mem_rd_addr;
    logic                     mem_rd_addr_ok;
    logic                     mem_ret_valid;
    logic [32*LINE_WORDS-1:0] mem_ret_data;
    logic                     miss_pulse;
`ifdef ICACHE_UNCACHED_EN
    logic                     uncached;
`endif

    modport slave (
        input  cpu_req_valid, cpu_req_addr, cpu_resp_ready, flush_req,
               mem_rd_addr_ok, mem_ret_valid, mem_ret_data,
`ifdef ICACHE_UNCACHED_EN
               uncached,
`endif
        output cpu_req_ready, cpu_resp_valid, cpu_resp_data, flush_busy,
               mem_rd_req, mem_rd_addr, miss_pulse
    );

    modport master (
        output cpu_req_valid, cpu_req_addr, cpu_resp_ready, flush_req,
               mem_rd_addr_ok, mem_ret_valid, mem_ret_data,
`ifdef ICACHE_UNCACHED_EN
               uncached,
`endif
        input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, flush_busy,
               mem_rd_req, mem_rd_addr, miss_pulse
    );
endinterface
`default_nettype wire

// File: rtl/icache_assoc.sv
`default_nettype none
// ============================================================================
// Module   : icache_assoc
// Brief    : Blocking N-way set-associative I-cache, tree-PLRU, flush sweep.
//            Optional ICACHE_UNCACHED_EN adds a per-request uncached bypass.
// Revision : 1.0
// ============================================================================
module icache_assoc #(
    parameter int WAYS       = 2,
    parameter int SETS       = 256,
    parameter int LINE_WORDS = 8
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    icache_assoc_if.slave     bus
);
    localparam int OFF_W  = $clog2(LINE_WORDS) + 2;
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W;
    localparam int WORD_W = OFF_W - 2;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int PLRU_W = (WAYS > 2) ? WAYS - 1 : 1;
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MISS   = 3'd2,
        S_REFILL = 3'd3,
        S_RESP   = 3'd4,
        S_FLUSH  = 3'd5
    } state_t;

    state_t              state_q;
    logic [31:2]         addr_q;
    logic [WAY_W-1:0]    victim_q;
    logic                ready_q;
    logic                flush_pend_q;
    logic [IDX_W-1:0]    flush_idx_q;
    logic [31:0]         resp_data_q;
    logic [31:0]         mem_addr_q;
    logic                miss_q;
    logic [WAYS-1:0]     valid_q [SETS];
    logic [PLRU_W-1:0]   plru_q  [SETS];

    logic [IDX_W-1:0]    w_idx;
    logic [IDX_W-1:0]    w_req_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [WORD_W-1:0]   w_off;
    logic                w_accept;
    logic                w_fill;
    logic                w_unc;
    logic [WAYS-1:0]     w_hit_vec;
    logic [WAYS-1:0][31:0] w_way_word;
    logic                w_hit;
    logic [WAY_W-1:0]    w_hit_way;
    logic [WAY_W-1:0]    w_victim;
    logic [WAY_W-1:0]    w_touch_way;
    logic [WAY_W-1:0]    w_plru_way;
    logic [PLRU_W-1:0]   w_plru_upd;

    assign w_idx       = addr_q[OFF_W +: IDX_W];
    assign w_tag       = addr_q[31 -: TAG_W];
    assign w_off       = addr_q[2 +: WORD_W];
    assign w_req_idx   = bus.cpu_req_addr[OFF_W +: IDX_W];
    assign w_accept    = (state_q == S_IDLE) && ready_q && !flush_pend_q && bus.cpu_req_valid;
    assign w_fill      = (state_q == S_REFILL) && bus.mem_ret_valid && !w_unc;
    assign w_touch_way = (state_q == S_LOOKUP) ? w_hit_way : victim_q;

`ifdef ICACHE_UNCACHED_EN
    logic unc_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        unc_q <= 1'b0;
        else if (w_accept) unc_q <= bus.uncached;
    end
    assign w_unc = unc_q;
`else
    assign w_unc = 1'b0;
`endif

    // Per-way storage: synchronous read issued on accept, compared in LOOKUP.
    for (genvar gw = 0; gw < WAYS; gw++) begin : g_way
        logic [TAG_W-1:0]  tag_mem  [SETS];
        logic [LINE_W-1:0] line_mem [SETS];
        logic [TAG_W-1:0]  rd_tag_q;
        logic [LINE_W-1:0] rd_line_q;

        always_ff @(posedge clk) begin
            if (w_fill && (victim_q == WAY_W'(gw))) begin
                tag_mem[w_idx]  <= w_tag;
                line_mem[w_idx] <= bus.mem_ret_data;
            end
            if (w_accept) begin
                rd_tag_q  <= tag_mem[w_req_idx];
                rd_line_q <= line_mem[w_req_idx];
            end
        end

        assign w_hit_vec[gw]  = valid_q[w_idx][gw] && (rd_tag_q == w_tag);
        assign w_way_word[gw] = rd_line_q[{w_off, 5'b0} +: 32];
    end

    if (WAYS == 4) begin : g_plru4
        // bit0 picks the victim half, bit1/bit2 the victim inside the left/right pair.
        logic [2:0] w_t;
        assign w_t        = plru_q[w_idx];
        assign w_plru_way = w_t[0] ? {1'b1, w_t[2]} : {1'b0, w_t[1]};
        assign w_plru_upd = w_touch_way[1] ? {~w_touch_way[0], w_t[1], 1'b0}
                                           : {w_t[2], ~w_touch_way[0], 1'b1};
    end else if (WAYS == 2) begin : g_plru2
        assign w_plru_way = plru_q[w_idx];
        assign w_plru_upd = ~w_touch_way;
    end else begin : g_plru1
        assign w_plru_way = 1'b0;
        assign w_plru_upd = plru_q[w_idx];
    end

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        w_victim  = w_plru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(w);
            end
            if (!valid_q[w_idx][w]) w_victim = WAY_W'(w);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            victim_q     <= '0;
            ready_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            flush_idx_q  <= '0;
            resp_data_q  <= '0;
            mem_addr_q   <= '0;
            miss_q       <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                plru_q[s]  <= '0;
            end
        end else begin
            miss_q <= 1'b0;
            // A request arriving while the sweep is starting or running is absorbed by it.
            if ((state_q == S_FLUSH) || ((state_q == S_IDLE) && flush_pend_q))
                flush_pend_q <= 1'b0;
            else if (bus.flush_req)
                flush_pend_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (flush_pend_q) begin
                        ready_q <= 1'b0;
                        state_q <= S_FLUSH;
                    end else if (w_accept) begin
                        ready_q <= 1'b0;
                        addr_q  <= bus.cpu_req_addr[31:2];
                        state_q <= S_LOOKUP;
                    end else begin
                        ready_q <= !bus.flush_req;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit && !w_unc) begin
                        resp_data_q   <= w_way_word[w_hit_way];
                        plru_q[w_idx] <= w_plru_upd;
                        state_q       <= S_RESP;
                    end else begin
                        victim_q   <= w_victim;
                        mem_addr_q <= w_unc ? {addr_q, 2'b00}
                                            : {addr_q[31:OFF_W], {OFF_W{1'b0}}};
                        miss_q     <= !w_unc;
                        state_q    <= S_MISS;
                    end
                end
                S_MISS: begin
                    if (bus.mem_rd_addr_ok) state_q <= S_REFILL;
                end
                S_REFILL: begin
                    if (bus.mem_ret_valid) begin
                        resp_data_q <= w_unc ? bus.mem_ret_data[31:0]
                                             : bus.mem_ret_data[{w_off, 5'b0} +: 32];
                        if (!w_unc) begin
                            valid_q[w_idx][victim_q] <= 1'b1;
                            plru_q[w_idx]            <= w_plru_upd;
                        end
                        state_q <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.cpu_resp_ready) begin
                        ready_q <= !(flush_pend_q || bus.flush_req);
                        state_q <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    valid_q[flush_idx_q] <= '0;
                    flush_idx_q          <= flush_idx_q + IDX_W'(1);
                    if (flush_idx_q == IDX_W'(SETS - 1)) begin
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.cpu_req_ready  = ready_q;
    assign bus.cpu_resp_valid = (state_q == S_RESP);
    assign bus.cpu_resp_data  = resp_data_q;
    assign bus.flush_busy     = (state_q == S_FLUSH);
    assign bus.mem_rd_req     = (state_q == S_MISS);
    assign bus.mem_rd_addr    = mem_addr_q;
    assign bus.miss_pulse     = miss_q;
endmodule
`default_nettype wire
